uart_rx_sampler: RTL and testbench
==================================

UART_RX_SAMPLER -- requirements
Module: uart_rx_sampler

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8, number of data bits per frame (5..8).
REQ-002 The block SHALL have parameter OVERSAMPLE, default 16, rx_tick pulses per bit period (fixed at 16; other values unsupported).
REQ-003 clk  input  1  system clock; all logic SHALL be clocked on posedge clk.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 rx_tick  input  1  single-clk enable pulse at 16x baud, synchronous to clk (baud generator rx output, edge-detected).
REQ-006 rxd  input  1  asynchronous serial line, idle high, 8N1 LSB-first.
REQ-007 rx_data  output  DATA_BITS  last accepted received byte.
REQ-008 rx_valid  output  1  rx_data holds an unconsumed byte.
REQ-009 rx_ready  input  1  consumer accepts rx_data when rx_valid && rx_ready.
REQ-010 frame_err  output  1  one-clk pulse: stop bit sampled low.
REQ-011 overrun  output  1  one-clk pulse: frame completed while previous byte unconsumed.
REQ-012 busy  output  1  high whenever FSM not in IDLE.

Function
REQ-013 rxd SHALL pass through a 2-flop synchronizer (reset value 1) before any use; all references below mean synchronized rxd_s.
REQ-014 FSM states SHALL be IDLE, START, DATA, STOP; a 4-bit oversample counter os_cnt and a bit counter SHALL advance only on clk cycles with rx_tick=1.
REQ-015 IDLE: on rx_tick with rxd_s=0 -> START, os_cnt<=0; otherwise remain.
REQ-016 START: each rx_tick increments os_cnt; at rx_tick with os_cnt=7 sample rxd_s: 0 -> DATA (os_cnt<=0, bit_cnt<=0); 1 -> IDLE (glitch rejected, no outputs asserted).
REQ-017 DATA: at rx_tick with os_cnt=15 sample rxd_s into shift register MSB, shift right (LSB first), os_cnt<=0, bit_cnt++; after DATA_BITS samples -> STOP.
REQ-018 STOP: at rx_tick with os_cnt=15 sample rxd_s; then -> IDLE in the same cycle regardless of result.
REQ-019 Stop sample 1 and (rx_valid=0 or rx_ready=1): rx_data<=shift register, rx_valid<=1 next clk.
REQ-020 Stop sample 1 and rx_valid=1 and rx_ready=0: new byte discarded, rx_data/rx_valid unchanged, overrun=1 for exactly one clk.
REQ-021 Stop sample 0: frame_err=1 for exactly one clk; rx_data/rx_valid unchanged; new byte discarded.
REQ-022 rx_valid SHALL stay high and rx_data stable until a clk with rx_ready=1; rx_valid then clears unless a new byte loads in that same clk (REQ-019), in which case it stays high with new data.
REQ-023 rx_ready while rx_valid=0 SHALL have no effect.
REQ-024 Sampling SHALL be at bit centre: first data sample 24 rx_ticks after start detection, subsequent samples every 16 rx_ticks.
REQ-025 Return to IDLE at stop-bit centre SHALL allow detection of a following start bit with no dead time.
REQ-026 rx_tick absent for arbitrary clks SHALL freeze the FSM without state change.

Reset
REQ-027 rst_n=0 at posedge clk SHALL force: state IDLE, os_cnt=0, bit_cnt=0, shift register=0, rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0, synchronizer flops=1.
REQ-028 Reset mid-frame SHALL discard the partial byte; reset SHALL take priority over all other events in the same clk.

Verification
REQ-029 rx_tick every 4 clk (bit=64 clk), rx_ready=1, send 0xA5 8N1 -> rx_data=0xA5, rx_valid pulses 1 clk, frame_err=overrun=0, busy low after stop centre.
REQ-030 rxd low for 3 rx_ticks then high -> no rx_valid, no frame_err, busy returns 0 within 8 rx_ticks of start detect.
REQ-031 Send 0x3C with stop bit driven 0 -> frame_err one-clk pulse, rx_valid stays 0, rx_data unchanged.
REQ-032 rx_ready=0, send 0x11 then 0x22 back-to-back -> rx_data=0x11 held, rx_valid=1, overrun pulse at second stop centre; then rx_ready=1 one clk -> rx_valid=0.
REQ-033 Assert rst_n=0 one clk after 4th data bit of 0xFF -> all outputs at reset values; next frame 0x5A received correctly.
REQ-034 Ten back-to-back frames 0x00..0x09, rx_ready=1, rx_tick gaps randomized 1..6 clk -> all ten bytes received in order, no errors.

Source files
------------

// File: rtl/uart_rx_sampler_if.sv
// Receive-side handshake bundle of the UART sampler: received byte with
// valid/ready, plus the framing-error, overrun and busy status signals.
interface uart_rx_sampler_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 frame_err;
  logic                 overrun;
  logic                 busy;

  modport master (output rx_data, rx_valid, frame_err, overrun, busy, input rx_ready);
  modport slave  (input rx_data, rx_valid, frame_err, overrun, busy, output rx_ready);
endinterface

// File: rtl/uart_rx_sampler.sv
// 8N1 UART receiver sampling at 16x baud: start-glitch rejection, bit-centre
// sampling, one-entry output register with valid/ready, framing/overrun pulses.
module uart_rx_sampler #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_tick,
  input  logic              rxd,
  uart_rx_sampler_if.master rx
);

  localparam logic [3:0] OS_LAST  = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] OS_MID   = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state, stateNext;
  logic                 rxdMeta, rxdS;
  logic [3:0]           osCnt, osCntNext;
  logic [2:0]           bitCnt, bitCntNext;
  logic [DATA_BITS-1:0] shiftReg, shiftNext;
  logic [DATA_BITS-1:0] rxDataNext;
  logic                 rxValidNext, frameErrNext, overrunNext;

  // NOTE: all state is updated with non-blocking assignments so every flop
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rxdMeta      <= 1'b1;
      rxdS         <= 1'b1;
      state        <= IDLE;
      osCnt        <= '0;
      bitCnt       <= '0;
      shiftReg     <= '0;
      rx.rx_data   <= '0;
      rx.rx_valid  <= 1'b0;
      rx.frame_err <= 1'b0;
      rx.overrun   <= 1'b0;
    end else begin
      rxdMeta      <= rxd;
      rxdS         <= rxdMeta;
      state        <= stateNext;
      osCnt        <= osCntNext;
      bitCnt       <= bitCntNext;
      shiftReg     <= shiftNext;
      rx.rx_data   <= rxDataNext;
      rx.rx_valid  <= rxValidNext;
      rx.frame_err <= frameErrNext;
      rx.overrun   <= overrunNext;
    end
  end

  // NOTE: every output of this block gets a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    stateNext    = state;
    osCntNext    = osCnt;
    bitCntNext   = bitCnt;
    shiftNext    = shiftReg;
    rxDataNext   = rx.rx_data;
    rxValidNext  = rx.rx_valid && !rx.rx_ready;
    frameErrNext = 1'b0;
    overrunNext  = 1'b0;

    if (rx_tick) begin
      unique case (state)
        IDLE: begin
          if (!rxdS) begin
            stateNext = START;
            osCntNext = '0;
          end
        end
        START: begin
          // Line must still be low at mid start bit, otherwise it was a glitch.
          if (osCnt == OS_MID) begin
            if (!rxdS) begin
              stateNext  = DATA;
              osCntNext  = '0;
              bitCntNext = '0;
            end else begin
              stateNext = IDLE;
            end
          end else begin
            osCntNext = osCnt + 4'd1;
          end
        end
        DATA: begin
          if (osCnt == OS_LAST) begin
            shiftNext  = {rxdS, shiftReg[DATA_BITS-1:1]};
            osCntNext  = '0;
            bitCntNext = bitCnt + 3'd1;
            if (bitCnt == BIT_LAST) stateNext = STOP;
          end else begin
            osCntNext = osCnt + 4'd1;
          end
        end
        STOP: begin
          // Leave at stop-bit centre so a following start edge is never missed.
          if (osCnt == OS_LAST) begin
            stateNext = IDLE;
            osCntNext = '0;
            if (!rxdS) begin
              frameErrNext = 1'b1;
            end else if (!rx.rx_valid || rx.rx_ready) begin
              rxDataNext  = shiftReg;
              rxValidNext = 1'b1;
            end else begin
              overrunNext = 1'b1;
            end
          end else begin
            osCntNext = osCnt + 4'd1;
          end
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  assign rx.busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Self-checking bench for uart_rx_sampler: tick-counted frame model with a
// per-cycle compare process, plus literal expectations for directed scenarios.
module tb_uart_rx_sampler;

  localparam int DATA_BITS    = 8;
  localparam int GLITCH_TICKS = 8;                          // start-centre check
  localparam int END_TICKS    = 8 + 16 * (DATA_BITS + 1);   // stop-bit centre

  logic clk = 1'b0;
  logic rst_n;
  logic rx_tick;
  logic rxd;

  uart_rx_sampler_if #(.DATA_BITS(DATA_BITS)) bus ();

  uart_rx_sampler #(.DATA_BITS(DATA_BITS), .OVERSAMPLE(16)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .rx_tick(rx_tick),
    .rxd    (rxd),
    .rx     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    bit         stopOk;
    bit         glitch;
    int         firstSeen;   // first clk edge at which the receiver can see the start level
  } frame_t;

  frame_t pend[$];
  logic [7:0] rxLog[$];

  int nChecks = 0;
  int nErrors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // rx_tick generator: fixed period of 4 clk, or random spacing of 1..6 clk.
  bit tickEn   = 1'b1;
  bit tickRand = 1'b0;
  int tickCnt  = 0;
  initial begin
    rx_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!tickEn) begin
        rx_tick = 1'b0;
      end else if (tickCnt == 0) begin
        rx_tick = 1'b1;
        tickCnt = tickRand ? int'($urandom_range(1, 6)) - 1 : 3;
      end else begin
        rx_tick = 1'b0;
        tickCnt--;
      end
    end
  end

  // Reference model: a frame completes a fixed number of ticks after its start
  // is first visible through the two-flop synchronizer.
  int         cyc        = 0;
  int         tickNum    = 0;
  int         headDetect = -1;
  bit         modelOn    = 1'b0;
  logic       mValid     = 1'b0;
  logic [7:0] mData      = 8'h00;
  logic       mBusy      = 1'b0;
  logic       expFe      = 1'b0;
  logic       expOv      = 1'b0;
  logic       oldValid;
  initial begin
    forever begin
      @(posedge clk);
      expFe = 1'b0;
      expOv = 1'b0;
      if (rst_n !== 1'b1) begin
        modelOn    = 1'b1;
        mValid     = 1'b0;
        mData      = 8'h00;
        mBusy      = 1'b0;
        headDetect = -1;
        pend.delete();
      end else if (modelOn) begin
        oldValid = mValid;
        if (mValid && bus.rx_ready) mValid = 1'b0;
        if (rx_tick && pend.size() > 0) begin
          if (headDetect < 0) begin
            if (cyc >= pend[0].firstSeen) begin
              headDetect = tickNum;
              mBusy      = 1'b1;
            end
          end else if (tickNum == headDetect + (pend[0].glitch ? GLITCH_TICKS : END_TICKS)) begin
            mBusy = 1'b0;
            if (!pend[0].glitch) begin
              if (!pend[0].stopOk) begin
                expFe = 1'b1;
              end else if (!oldValid || bus.rx_ready) begin
                mData  = pend[0].data;
                mValid = 1'b1;
              end else begin
                expOv = 1'b1;
              end
            end
            pend.delete(0);
            headDetect = -1;
          end
        end
      end
      if (rx_tick) tickNum++;
      cyc++;
    end
  end

  // Compare process plus observation counters for the directed checks.
  int validCycles = 0;
  int feCount     = 0;
  int ovCount     = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (modelOn) begin
        check("rx_valid",  32'(bus.rx_valid),  32'(mValid));
        check("rx_data",   32'(bus.rx_data),   32'(mData));
        check("frame_err", 32'(bus.frame_err), 32'(expFe));
        check("overrun",   32'(bus.overrun),   32'(expOv));
        check("busy",      32'(bus.busy),      32'(mBusy));
        if (bus.rx_valid === 1'b1) validCycles++;
        if (bus.rx_valid === 1'b1 && bus.rx_ready === 1'b1) rxLog.push_back(bus.rx_data);
        if (bus.frame_err === 1'b1) feCount++;
        if (bus.overrun === 1'b1) ovCount++;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: time limit reached, CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $fatal(1, "watchdog");
  end

  task automatic waitTicks(input int n);
    for (int i = 0; i < n; i++) begin
      do @(posedge clk); while (rx_tick !== 1'b1);
    end
  endtask

  // Entered at a tick edge; leaves at the tick edge ending the stop bit.
  task automatic sendFrame(input logic [7:0] data, input bit stopBit);
    frame_t f;
    #1 rxd = 1'b0;
    f.data      = data;
    f.stopOk    = stopBit;
    f.glitch    = 1'b0;
    f.firstSeen = cyc + 2;
    pend.push_back(f);
    if (!stopBit) begin
      // Line is still low at stop centre, so the receiver restarts and rejects it.
      f.glitch    = 1'b1;
      f.firstSeen = 0;
      pend.push_back(f);
    end
    waitTicks(16);
    for (int i = 0; i < DATA_BITS; i++) begin
      #1 rxd = data[i];
      waitTicks(16);
    end
    #1 rxd = stopBit;
    waitTicks(16);
  endtask

  task automatic sendGlitch();
    frame_t f;
    #1 rxd = 1'b0;
    f.data      = 8'h00;
    f.stopOk    = 1'b1;
    f.glitch    = 1'b1;
    f.firstSeen = cyc + 2;
    pend.push_back(f);
    waitTicks(3);
    #1 rxd = 1'b1;
  endtask

  task automatic lineIdle(input int n);
    #1 rxd = 1'b1;
    waitTicks(n);
  endtask

  int baseValid, baseFe, baseOv, baseLog;
  bit randDone;

  task automatic snapshot();
    baseValid = validCycles;
    baseFe    = feCount;
    baseOv    = ovCount;
    baseLog   = rxLog.size();
  endtask

  initial begin
    rxd          = 1'b1;
    rst_n        = 1'b0;
    bus.rx_ready = 1'b1;
    randDone     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset rx_valid",  32'(bus.rx_valid),  32'h0);
    check("reset rx_data",   32'(bus.rx_data),   32'h0);
    check("reset busy",      32'(bus.busy),      32'h0);
    check("reset frame_err", 32'(bus.frame_err), 32'h0);
    check("reset overrun",   32'(bus.overrun),   32'h0);
    rst_n = 1'b1;

    // 0xA5 with ready held high: one-clk valid pulse, no errors.
    snapshot();
    waitTicks(1);
    sendFrame(8'hA5, 1'b1);
    lineIdle(20);
    check("A5 rx_data",      32'(bus.rx_data), 32'hA5);
    check("A5 valid cycles", 32'(validCycles - baseValid), 32'd1);
    check("A5 logged byte",  32'(rxLog[baseLog]), 32'hA5);
    check("A5 no errors",    32'(feCount - baseFe + ovCount - baseOv), 32'd0);
    check("A5 busy idle",    32'(bus.busy), 32'h0);

    // Short low pulse on the line is rejected silently.
    snapshot();
    sendGlitch();
    lineIdle(12);
    check("glitch busy",  32'(bus.busy), 32'h0);
    check("glitch valid", 32'(validCycles - baseValid), 32'd0);
    check("glitch fe",    32'(feCount - baseFe), 32'd0);

    // 0x3C with a low stop bit: framing-error pulse, output untouched.
    snapshot();
    sendFrame(8'h3C, 1'b0);
    lineIdle(24);
    check("3C fe pulses",  32'(feCount - baseFe), 32'd1);
    check("3C valid",      32'(validCycles - baseValid), 32'd0);
    check("3C rx_data",    32'(bus.rx_data), 32'hA5);

    // Two frames with no consumer: second one overruns.
    snapshot();
    bus.rx_ready = 1'b0;
    sendFrame(8'h11, 1'b1);
    sendFrame(8'h22, 1'b1);
    lineIdle(20);
    check("ovr rx_data",  32'(bus.rx_data), 32'h11);
    check("ovr rx_valid", 32'(bus.rx_valid), 32'h1);
    check("ovr pulses",   32'(ovCount - baseOv), 32'd1);
    @(posedge clk);
    #1 bus.rx_ready = 1'b1;
    @(posedge clk);
    #1 bus.rx_ready = 1'b0;
    @(negedge clk);
    check("ovr consumed", 32'(bus.rx_valid), 32'h0);
    check("ovr logged",   32'(rxLog[baseLog]), 32'h11);
    @(posedge clk);
    #1 bus.rx_ready = 1'b1;

    // Reset in the middle of 0xFF, then 0x5A with the tick stream frozen a while.
    snapshot();
    waitTicks(1);
    fork
      sendFrame(8'hFF, 1'b1);
      begin
        waitTicks(16 + 16 * 4);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("midreset rx_data", 32'(bus.rx_data), 32'h0);
        check("midreset busy",    32'(bus.busy), 32'h0);
      end
    join
    check("FF discarded", 32'(validCycles - baseValid), 32'd0);
    fork
      sendFrame(8'h5A, 1'b1);
      begin
        waitTicks(50);
        tickEn = 1'b0;
        repeat (40) @(posedge clk);
        tickEn = 1'b1;
      end
    join
    lineIdle(20);
    check("5A rx_data", 32'(bus.rx_data), 32'h5A);
    check("5A logged",  32'(rxLog[baseLog]), 32'h5A);

    // Ten back-to-back frames with random tick spacing.
    snapshot();
    tickRand = 1'b1;
    waitTicks(1);
    for (int i = 0; i < 10; i++) sendFrame(8'(i), 1'b1);
    lineIdle(20);
    check("burst count", 32'(rxLog.size() - baseLog), 32'd10);
    for (int i = 0; i < 10; i++) check("burst byte", 32'(rxLog[baseLog + i]), 32'(i));
    check("burst errors", 32'(feCount - baseFe + ovCount - baseOv), 32'd0);

    // Random bytes against a randomly stalling consumer.
    waitTicks(1);
    fork
      begin
        for (int i = 0; i < 8; i++) sendFrame(8'($urandom), 1'b1);
        lineIdle(20);
        randDone = 1'b1;
      end
      begin
        while (!randDone) begin
          @(posedge clk);
          #1 bus.rx_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    bus.rx_ready = 1'b1;
    repeat (4) @(posedge clk);
    check("model drained", 32'(pend.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

endmodule
